binary_to_bcd_seq: RTL and testbench
====================================

# binary_to_bcd_seq

Sequential binary-to-BCD converter: takes an unsigned binary value on a start strobe and produces `DIGITS` packed BCD nibbles using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the per-digit seven-segment decoders. Each output nibble feeds one decoder instance, and `blank_mask` lets the top level force leading-zero displays dark.

## Interface
Parameters:
- `BIN_WIDTH`, 20: width of the binary input.
- `DIGITS`, 6: number of BCD digits produced. Digit 0 is least significant.

Ports:
- `clk` input 1: single system clock, rising-edge.
- `rst_n` input 1: reset. Reset is asynchronous and active-low.
- `start` input 1: request conversion of `bin_in`. Sampled only in IDLE.
- `bin_in` input `BIN_WIDTH`: unsigned value to convert. Sampled on the accepting edge only.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `bcd_out`, `blank_mask` and `overflow` update.
- `bcd_out` output `4*DIGITS`: packed BCD. Digit i is in bits [4i+3:4i].
- `blank_mask` output `DIGITS`: bit i=1 when digit i is a leading zero. Bit 0 is always 0.
- `overflow` output 1: the last converted value exceeded 10^DIGITS−1.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: iterates over the bits of the latched value.
- IDLE with `start`=1 at an edge:
  - Latch `bin_in` into the shift register.
  - Clear the BCD scratch register.
  - Load the bit counter with `BIN_WIDTH`.
  - Register the overflow compare `bin_in > MAX_VAL`.
  - Go to SHIFT.
- SHIFT, each edge:
  - Apply add-3 to every scratch digit ≥5.
  - Shift {scratch, shift register} left by one.
  - Decrement the counter.
- When the counter reaches 1 during a SHIFT edge, that edge is the final shift. On the next edge:
  - `bcd_out` ← scratch, or all digits 4'h9 if the overflow flag is set.
  - `blank_mask` ← computed from the new digits.
  - `overflow` ← the flag.
  - `done` ← 1.
  - State ← IDLE.
- `blank_mask[i]` = 1 iff digits i..DIGITS−1 are all zero and i≠0.
- `start` is ignored while `busy` is high. A pending value is not queued.
- Outputs hold their last values between conversions.
- Scratch width is exactly `4*DIGITS`. When overflow is set, bits carried out of the top are discarded and the saturated result replaces them.
- Reset mid-conversion:
  - The conversion is aborted immediately.
  - No `done` pulse is produced.
  - All outputs take their reset values.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `overflow`=0.
  - `bcd_out`=0.
  - `blank_mask`={DIGITS−1 ones, 0}.
- Start accepted at edge E:
  - `busy` rises after E.
  - `done` is high for exactly one cycle, following edge E+`BIN_WIDTH`+1. Outputs change on that same edge.
  - `busy` falls on that same edge.
- `busy` is high for exactly `BIN_WIDTH`+1 cycles per conversion.
- The FSM is back in IDLE during the `done` cycle. A `start` in that cycle is accepted, giving back-to-back conversions every `BIN_WIDTH`+1 cycles.
- No combinational path from any input to any output.

## Structure
- Package `bcd_pkg` holds:
  - State enum `bcd_state_t` (IDLE, SHIFT).
  - Function `pow10(n)`.
  - Constant derivation `MAX_VAL = pow10(DIGITS)−1`. When `BIN_WIDTH` cannot exceed `MAX_VAL`, the overflow compare is constant 0.
- Sub-module `bcd_add3`: combinational, 4-bit in/out, output = in+3 if in≥5 else in. Instantiated `DIGITS` times via generate.
- Top file holds the FSM, bit counter, shift/scratch registers, output registers, and blank-mask logic.

## Test plan
- Reset check: hold `rst_n`=0 → `busy`=0, `done`=0, `overflow`=0, `bcd_out`=24'h000000, `blank_mask`=6'b111110.
- Nominal conversion: `bin_in`=123456 with a 1-cycle `start` → `done` exactly 21 cycles after the accepting edge, `bcd_out`=24'h123456, `blank_mask`=6'b000000, `overflow`=0.
- Leading-zero blanking:
  - `bin_in`=42 → `bcd_out`=24'h000042, `blank_mask`=6'b111100.
  - `bin_in`=0 → `bcd_out`=0, `blank_mask`=6'b111110.
- Saturation boundary:
  - `bin_in`=999999 → 24'h999999, `overflow`=0.
  - `bin_in`=1000000 → 24'h999999, `overflow`=1.
  - `bin_in`=20'hFFFFF → 24'h999999, `overflow`=1.
- Handshake:
  - `start` with 7 pulsed mid-conversion of 555 → ignored, result 24'h000555.
  - `start` with 321 held high in the `done` cycle → accepted, second `done` 21 cycles later with 24'h000321.
- Reset mid-operation: assert `rst_n`=0 ten cycles into converting 777777 → no `done`, outputs at reset values. The next conversion of 314159 yields 24'h314159.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : shared types and constant helpers for the binary-to-BCD converter
// Revision : 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  // Elaboration-time power of ten, wide enough for any realistic DIGITS.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int k = 0; k < n; k++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

  function automatic logic [63:0] max_val(input int digits);
    return pow10(digits) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_add3 : double-dabble digit correction, adds 3 to nibbles of 5 or more
// Revision : 1.0
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// binary_to_bcd_seq : one-bit-per-clock double-dabble converter, saturating
// Revision : 1.0
// ---------------------------------------------------------------------------
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  overflow
);

  localparam int          CNT_W        = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL      = max_val(DIGITS);
  localparam bit          OVF_POSSIBLE = (BIN_WIDTH >= 64) ||
                                         (((64'd1 << BIN_WIDTH) - 64'd1) > MAX_VAL);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  bcd_state_t             state_q, state_d;
  logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
  logic [4*DIGITS-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [4*DIGITS-1:0]    adj;
  logic [4*DIGITS-1:0]    result_sel;
  logic [DIGITS-1:0]      blank_calc;
  logic                   ovf_cmp;
  logic                   zero_run;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_add3 u_add3 (
        .din  (scratch_q[4*i +: 4]),
        .dout (adj[4*i +: 4])
      );
    end

    if (OVF_POSSIBLE) begin : g_ovf_cmp
      assign ovf_cmp = 64'(bin_in) > MAX_VAL;
    end else begin : g_ovf_none
      assign ovf_cmp = 1'b0;
    end
  endgenerate

  assign result_sel = ovf_flag_q ? {DIGITS{4'h9}} : scratch_q;

  // A digit blanks only if it and every more significant digit are zero.
  always_comb begin
    zero_run   = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (result_sel[4*i +: 4] == 4'h0);
      blank_calc[i] = zero_run;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_WIDTH);
          ovf_flag_d = ovf_cmp;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          // Carries out of the top digit are dropped; saturation covers them.
          scratch_d = (adj << 1) | {{(4*DIGITS-1){1'b0}}, shreg_q[BIN_WIDTH-1]};
          shreg_d   = shreg_q << 1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          bcd_d   = result_sel;
          blank_d = blank_calc;
          ovf_d   = ovf_flag_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign bcd_out    = bcd_q;
  assign blank_mask = blank_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_seq : directed self-checking bench for binary_to_bcd_seq
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic [5:0]  blank_mask;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int lat;

  binary_to_bcd_seq #(
    .BIN_WIDTH (20),
    .DIGITS    (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle start; returns just after the accepting edge.
  task automatic kick(input logic [19:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(input int from, output int l);
    l = -1;
    for (int k = from; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic convert(input string tag, input logic [19:0] v,
                         input logic [23:0] e_bcd, input logic [5:0] e_blank,
                         input logic e_ovf);
    int l;
    kick(v);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(1, l);
    check({tag, "_lat"}, l, 32'd21);
    check({tag, "_bcd"}, {8'd0, bcd_out}, {8'd0, e_bcd});
    check({tag, "_blank"}, {26'd0, blank_mask}, {26'd0, e_blank});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_done",  {31'd0, done},        32'd0);
    check("rst_ovf",   {31'd0, overflow},    32'd0);
    check("rst_bcd",   {8'd0, bcd_out},      32'h000000);
    check("rst_blank", {26'd0, blank_mask},  32'b111110);
    @(negedge clk);
    rst_n = 1'b1;

    convert("nom",     20'd123456,  24'h123456, 6'b000000, 1'b0);
    convert("lz42",    20'd42,      24'h000042, 6'b111100, 1'b0);
    convert("zero",    20'd0,       24'h000000, 6'b111110, 1'b0);
    convert("max",     20'd999999,  24'h999999, 6'b000000, 1'b0);
    convert("sat1m",   20'd1000000, 24'h999999, 6'b000000, 1'b1);
    convert("satfff",  20'hFFFFF,   24'h999999, 6'b000000, 1'b1);
    convert("clr_ovf", 20'd7,       24'h000007, 6'b111110, 1'b0);

    // start pulsed mid-conversion is ignored
    kick(20'd555);
    repeat (5) @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 20'd7;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done(7, lat);
    check("ign_lat", lat, 32'd21);
    check("ign_bcd", {8'd0, bcd_out}, 32'h000555);
    check("ign_blank", {26'd0, blank_mask}, 32'b111000);
    @(posedge clk);
    #1;
    check("ign_idle", {31'd0, busy}, 32'd0);

    // start held during the done cycle is accepted back-to-back
    kick(20'd100);
    wait_done(1, lat);
    check("b2b_first_lat", lat, 32'd21);
    check("b2b_first_bcd", {8'd0, bcd_out}, 32'h000100);
    start  = 1'b1;
    bin_in = 20'd321;
    @(posedge clk);
    #1;
    start  = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    check("b2b_lat", lat, 32'd21);
    check("b2b_bcd", {8'd0, bcd_out}, 32'h000321);
    check("b2b_blank", {26'd0, blank_mask}, 32'b111000);

    // reset ten cycles into a conversion
    kick(20'd777777);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy",  {31'd0, busy},       32'd0);
    check("mrst_bcd",   {8'd0, bcd_out},     32'h000000);
    check("mrst_blank", {26'd0, blank_mask}, 32'b111110);
    check("mrst_ovf",   {31'd0, overflow},   32'd0);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) check("mrst_no_done", {31'd0, done}, 32'd0);
    end
    check("mrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("mrst_stay_idle", {31'd0, busy}, 32'd0);
    check("mrst_hold_bcd", {8'd0, bcd_out}, 32'h000000);

    convert("post_rst", 20'd314159, 24'h314159, 6'b000000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
